// File: rtl/pedal_spi_pkg.sv
// Shared constants, types and helpers for the SPI ADC responder.
// Provides frame geometry, address-bit positions, the FSM state enum,
// the synchronized-edge bundle and the channel-select helper.
package pedal_spi_pkg;

  localparam int unsigned FRAME_BITS     = 16;
  localparam int unsigned ADDR_FIRST_BIT = 2;
  localparam int unsigned ADDR_LAST_BIT  = 4;
  localparam int unsigned CH_W           = 12;
  localparam int unsigned NUM_CH         = 8;
  localparam int unsigned ADDR_W         = 3;
  localparam int unsigned CNT_W          = 4;
  localparam int unsigned CH_BUS_W       = CH_W * NUM_CH;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  // Synchronized level plus single-cycle rise/fall strobes of one pin.
  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } sync_edge_t;

  // Frame word for a channel: sample zero-extended into the 16-bit frame.
  function automatic logic [FRAME_BITS-1:0] frame_word(
    input logic [CH_BUS_W-1:0] ch,
    input logic [ADDR_W-1:0]   addr
  );
    frame_word = FRAME_BITS'(ch[addr * CH_W +: CH_W]);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with rise/fall detection for one async pin.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   pin         - asynchronous input
//   sync_c      - synchronized level and one-clk rise/fall strobes
module spi_sync_edge
  import pedal_spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        IDLE_LEVEL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pin,
  output sync_edge_t sync_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchronizer chain plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
      prev_q <= IDLE_LEVEL;
    end else begin
      sync_q <= SYNC_STAGES'({sync_q, pin});
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    sync_c.level = sync_q[SYNC_STAGES-1];
    sync_c.rise  = sync_q[SYNC_STAGES-1] & ~prev_q;
    sync_c.fall  = ~sync_q[SYNC_STAGES-1] & prev_q;
  end

endmodule

// File: rtl/adc_spi_responder.sv
// SPI responder presenting one of eight 12-bit ADC samples per 16-bit frame.
// The channel address sent in a frame selects the sample of the next frame.
// Ports:
//   clk, reset   - system clock, synchronous active-high reset
//   sclk, cs_b   - SPI clock (idles high) and active-low select, async
//   din          - master-to-responder bits (address in bits 2..4)
//   ch_data      - eight packed 12-bit channel samples
//   dout         - serial sample, MSB first
//   addr_out     - currently selected channel
//   frame_done   - one-clk pulse on a completed frame
//   frame_err    - one-clk pulse when cs_b rises mid-frame
//   active       - high while a frame is selected
module adc_spi_responder
  import pedal_spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sclk,
  input  logic                cs_b,
  input  logic                din,
  input  logic [CH_BUS_W-1:0] ch_data,
  output logic                dout,
  output logic [ADDR_W-1:0]   addr_out,
  output logic                frame_done,
  output logic                frame_err,
  output logic                active
);

  sync_edge_t sclk_s;
  sync_edge_t cs_s;
  sync_edge_t din_s;

  spi_state_e state_q;
  spi_state_e state_d;

  logic [FRAME_BITS-1:0] shift_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [ADDR_W-1:0]     addr_cap_q;
  logic [ADDR_W-1:0]     cur_addr_q;
  logic [SYNC_STAGES:0]  flush_q;
  logic                  armed_q;

  logic                  cs_fall_c;
  logic                  cs_rise_c;
  logic                  sclk_rise_c;
  logic                  sclk_fall_c;
  logic                  cap_win_c;
  logic [CNT_W-1:0]      cap_sel_c;
  logic                  dout_c;
  logic                  frame_done_c;
  logic                  frame_err_c;
  logic                  active_c;
  logic                  unused_sync_c;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_sclk (
    .clk    (clk),
    .reset  (reset),
    .pin    (sclk),
    .sync_c (sclk_s)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_cs (
    .clk    (clk),
    .reset  (reset),
    .pin    (cs_b),
    .sync_c (cs_s)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_din (
    .clk    (clk),
    .reset  (reset),
    .pin    (din),
    .sync_c (din_s)
  );

  assign unused_sync_c = ^{sclk_s.level, din_s.rise, din_s.fall};

  // A cs_b fall only counts once the synchronizer has flushed after reset and
  // cs_b has been seen high; a select held low through reset is not a frame.
  assign cs_fall_c   = cs_s.fall & armed_q & (state_q == IDLE);
  assign cs_rise_c   = cs_s.rise & (state_q == ACTIVE);
  assign sclk_rise_c = sclk_s.rise & (state_q == ACTIVE) & ~cs_s.rise;
  assign sclk_fall_c = sclk_s.fall & (state_q == ACTIVE) & ~cs_s.rise;

  // Address bit k of the frame lands in addr_cap[ADDR_LAST_BIT - k].
  assign cap_sel_c = CNT_W'(ADDR_LAST_BIT) - bit_cnt_q;
  assign cap_win_c = (bit_cnt_q >= CNT_W'(ADDR_FIRST_BIT)) &&
                     (bit_cnt_q <= CNT_W'(ADDR_LAST_BIT));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall_c) state_d = ACTIVE;
      ACTIVE:  if (cs_rise_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode, registered below.
  always_comb begin
    dout_c       = 1'b0;
    frame_done_c = 1'b0;
    frame_err_c  = 1'b0;
    active_c     = 1'b0;
    if (state_q == ACTIVE) begin
      dout_c = shift_q[FRAME_BITS-1];
    end
    if (sclk_rise_c && (bit_cnt_q == CNT_W'(FRAME_BITS - 1))) begin
      frame_done_c = 1'b1;
    end
    if (cs_rise_c && (bit_cnt_q != '0)) begin
      frame_err_c = 1'b1;
    end
    active_c = (state_d == ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout       <= 1'b0;
      addr_out   <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      active     <= 1'b0;
    end else begin
      dout       <= dout_c;
      addr_out   <= cur_addr_q;
      frame_done <= frame_done_c;
      frame_err  <= frame_err_c;
      active     <= active_c;
    end
  end

  // Post-reset arming of the chip-select fall detector.
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_q <= '0;
      armed_q <= 1'b0;
    end else begin
      flush_q <= (SYNC_STAGES + 1)'({flush_q, 1'b1});
      armed_q <= armed_q | (flush_q[SYNC_STAGES] & cs_s.level);
    end
  end

  // Frame datapath: load on select, count/capture on rise, shift on fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      addr_cap_q <= '0;
      cur_addr_q <= '0;
    end else if (cs_fall_c) begin
      shift_q   <= frame_word(ch_data, cur_addr_q);
      bit_cnt_q <= '0;
    end else if (cs_rise_c) begin
      addr_cap_q <= '0;
    end else begin
      if (sclk_rise_c) begin
        if (cap_win_c) begin
          addr_cap_q[cap_sel_c[ADDR_W-1:0]] <= din_s.level;
        end
        if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
          bit_cnt_q  <= '0;
          cur_addr_q <= addr_cap_q;
        end else begin
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        end
      end
      // Reload at bit 0 keeps back-to-back frames aligned under a held cs_b.
      if (sclk_fall_c) begin
        if (bit_cnt_q == '0) begin
          shift_q <= frame_word(ch_data, cur_addr_q);
        end else begin
          shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Self-checking bench for adc_spi_responder: table of single frames plus
// hand-written continuous, abort, coincident-edge and mid-frame reset cases.
module tb_adc_spi_responder;

  localparam int HALF = 8;

  logic        clk;
  logic        reset;
  logic        sclk;
  logic        cs_b;
  logic        din;
  logic [95:0] ch_data;
  logic        dout;
  logic [2:0]  addr_out;
  logic        frame_done;
  logic        frame_err;
  logic        active;

  int n_cmp;
  int n_bad;
  int done_cnt;
  int err_cnt;

  logic [15:0] exp_q[$];

  typedef struct {
    logic [2:0]  add;
    logic [15:0] exp_word;
    logic [2:0]  exp_addr;
  } vec_t;

  vec_t vecs[6];

  adc_spi_responder #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .sclk       (sclk),
    .cs_b       (cs_b),
    .din        (din),
    .ch_data    (ch_data),
    .dout       (dout),
    .addr_out   (addr_out),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .active     (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sclk_bit(input logic b, input bit skip_fall, output logic s);
    if (!skip_fall) sclk = 1'b0;
    din = b;
    wait_clk(HALF);
    s = dout;
    sclk = 1'b1;
    wait_clk(HALF);
  endtask

  // Clock out nbits of a frame carrying address add; returns bits read.
  task automatic run_frame(input logic [2:0] add, input bit coinc, input int nbits,
                           output logic [15:0] word);
    logic [15:0] tx;
    logic        s;
    tx   = {2'b00, add, 11'd0};
    word = '0;
    for (int i = 0; i < nbits; i++) begin
      sclk_bit(tx[15-i], coinc && (i == 0), s);
      word = {word[14:0], s};
    end
  endtask

  task automatic cs_start(input bit coinc);
    cs_b = 1'b0;
    if (coinc) sclk = 1'b0;
    else wait_clk(HALF);
  endtask

  task automatic cs_end();
    wait_clk(HALF);
    cs_b = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sclk  = 1'b1;
    cs_b  = 1'b1;
    din   = 1'b0;
    wait_clk(3);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_addr", 32'(addr_out), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    reset = 1'b0;
    wait_clk(10);
  endtask

  // Full frame checked through the scoreboard.
  task automatic sb_frame(input string name, input logic [2:0] add, input logic [15:0] exp,
                          input bit coinc);
    logic [15:0] w;
    exp_q.push_back(exp);
    cs_start(coinc);
    run_frame(add, coinc, 16, w);
    cs_end();
    check(name, 32'(w), 32'(exp_q.pop_front()));
  endtask

  initial begin
    logic [15:0] w;
    int d0;
    int e0;
    n_cmp    = 0;
    n_bad    = 0;
    done_cnt = 0;
    err_cnt  = 0;
    ch_data  = {12'h800, 12'hFFF, 12'h123, 12'h321, 12'hDEF, 12'h789, 12'h456, 12'hABC};

    vecs[0] = '{3'd5, 16'h0ABC, 3'd5};
    vecs[1] = '{3'd2, 16'h0123, 3'd2};
    vecs[2] = '{3'd7, 16'h0789, 3'd7};
    vecs[3] = '{3'd0, 16'h0800, 3'd0};
    vecs[4] = '{3'd3, 16'h0ABC, 3'd3};
    vecs[5] = '{3'd6, 16'h0DEF, 3'd6};

    do_reset();

    // Single frames, each under its own chip select.
    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      sb_frame($sformatf("vec%0d_word", i), vecs[i].add, vecs[i].exp_word, 1'b0);
      check($sformatf("vec%0d_done", i), 32'(done_cnt - d0), 32'd1);
      check($sformatf("vec%0d_err", i), 32'(err_cnt - e0), 32'd0);
      check($sformatf("vec%0d_addr", i), 32'(addr_out), 32'(vecs[i].exp_addr));
      check($sformatf("vec%0d_idle_dout", i), 32'(dout), 32'd0);
    end

    // Three back-to-back frames under one continuous chip select.
    do_reset();
    d0 = done_cnt;
    e0 = err_cnt;
    cs_start(1'b0);
    check("cont_active", 32'(active), 32'd1);
    for (int f = 0; f < 3; f++) begin
      case (f)
        0:       exp_q.push_back(16'h0ABC);
        1:       exp_q.push_back(16'h0456);
        default: exp_q.push_back(16'h0789);
      endcase
      run_frame(3'(f + 1), 1'b0, 16, w);
      check($sformatf("cont%0d_word", f), 32'(w), 32'(exp_q.pop_front()));
    end
    cs_end();
    check("cont_done", 32'(done_cnt - d0), 32'd3);
    check("cont_err", 32'(err_cnt - e0), 32'd0);
    check("cont_addr", 32'(addr_out), 32'd3);

    // Abort after 7 rises: address 7 must be discarded.
    d0 = done_cnt;
    e0 = err_cnt;
    cs_start(1'b0);
    run_frame(3'd7, 1'b0, 7, w);
    cs_b = 1'b1;
    wait_clk(2 * HALF);
    check("abort_err", 32'(err_cnt - e0), 32'd1);
    check("abort_done", 32'(done_cnt - d0), 32'd0);
    check("abort_addr", 32'(addr_out), 32'd3);
    check("abort_dout", 32'(dout), 32'd0);
    check("abort_active", 32'(active), 32'd0);
    sb_frame("post_abort_word", 3'd0, 16'h0DEF, 1'b0);
    check("post_abort_addr", 32'(addr_out), 32'd0);

    // cs_b and sclk fall together: load only, no early shift.
    sb_frame("coinc_word", 3'd4, 16'h0ABC, 1'b1);
    check("coinc_addr", 32'(addr_out), 32'd4);

    // Reset after 9 rises: outputs clear, frame abandoned silently.
    d0 = done_cnt;
    e0 = err_cnt;
    cs_start(1'b0);
    run_frame(3'd7, 1'b0, 9, w);
    reset = 1'b1;
    wait_clk(1);
    check("mrst_dout", 32'(dout), 32'd0);
    check("mrst_addr", 32'(addr_out), 32'd0);
    check("mrst_done", 32'(frame_done), 32'd0);
    check("mrst_err", 32'(frame_err), 32'd0);
    check("mrst_active", 32'(active), 32'd0);
    wait_clk(2);
    reset = 1'b0;
    wait_clk(4);
    run_frame(3'd0, 1'b0, 7, w);
    check("mrst_ignored_dout", 32'(w), 32'd0);
    check("mrst_ignored_active", 32'(active), 32'd0);
    cs_end();
    check("mrst_no_done", 32'(done_cnt - d0), 32'd0);
    check("mrst_no_err", 32'(err_cnt - e0), 32'd0);
    sb_frame("post_rst_word", 3'd7, 16'h0ABC, 1'b0);
    check("post_rst_addr", 32'(addr_out), 32'd7);
    sb_frame("post_rst_word2", 3'd0, 16'h0800, 1'b0);
    check("post_rst_done", 32'(done_cnt - d0), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
